// File: rtl/muldiv_unit.sv
// Multiply/divide unit: single-cycle MULT/MULTU, restoring radix-2 DIV/DIVU (divider only with `MULDIV_DIV_EN).
// Latency: MUL 2 cycles, DIV WIDTH+1 cycles (2 on divide-by-zero or without the divider); busy_o stalls the issuer.
// Backpressure: start_i is taken only in IDLE/DONE; cancel_i aborts in-flight work and leaves results untouched.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state_q, state_d;
    logic               accept;
    logic               sgn_q;
    logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
    logic               dz_q;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               res_dz;
    logic               div_last;
    logic [2*WIDTH-1:0] prod;

    // Sign-extending to 2*WIDTH lets one unsigned multiply serve both MULT and MULTU.
    assign prod = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q} * {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};

`ifdef MULDIV_DIV_EN
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q;
    logic [WIDTH-1:0] a_in_mag, dvs, rem_nxt, quo_nxt;
    logic [WIDTH:0]   rem_sh, diff;
    logic             a_neg, b_neg, b_zero, ge;

    always_comb begin
        a_in_mag = (!op_i[0] && opa_i[WIDTH-1]) ? -opa_i : opa_i;
        a_neg    = sgn_q & a_q[WIDTH-1];
        b_neg    = sgn_q & b_q[WIDTH-1];
        b_zero   = (b_q == '0);
        dvs      = b_neg ? -b_q : b_q;
        rem_sh   = {rem_q, quo_q[WIDTH-1]};
        diff     = rem_sh - {1'b0, dvs};
        ge       = ~diff[WIDTH];
        rem_nxt  = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nxt  = {quo_q[WIDTH-2:0], ge};
        div_last = b_zero || (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= a_in_mag;
        end else if (state_q == DIV) begin
            cnt_q <= cnt_q + 1'b1;
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end
`else
    assign div_last = 1'b1;
`endif

    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        res_dz = 1'b0;
        if (state_q == DIV) begin
`ifdef MULDIV_DIV_EN
            if (b_zero) begin
                res_hi = a_q;
                res_lo = '1;
                res_dz = 1'b1;
            end else begin
                // Truncating division: quotient sign from operand signs, remainder follows dividend.
                res_lo = (a_neg ^ b_neg) ? -quo_nxt : quo_nxt;
                res_hi = a_neg ? -rem_nxt : rem_nxt;
            end
`else
            res_hi = '0;
            res_lo = '0;
            res_dz = 1'b1;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_i && !cancel_i) begin
                    accept  = 1'b1;
                    state_d = op_i[1] ? DIV : MUL;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL:     state_d = cancel_i ? IDLE : DONE;
            DIV: begin
                if (cancel_i)      state_d = IDLE;
                else if (div_last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sgn_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sgn_q <= ~op_i[0];
                a_q   <= opa_i;
                b_q   <= opb_i;
                dz_q  <= 1'b0;
            end
            if (state_d == DONE) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
                dz_q <= res_dz;
            end
        end
    end

    assign busy_o     = (state_q == MUL) || (state_q == DIV);
    assign done_o     = (state_q == DONE);
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign div_zero_o = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (WIDTH=32): scoreboard of expected results/done cycles popped on done_o.
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_DIV_EN
    localparam int DIV_LAT   = W + 1;
    localparam int CANCEL_AT = 10;
`else
    localparam int DIV_LAT   = 2;
    localparam int CANCEL_AT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [1:0]   op_i = 2'b00;
    logic [W-1:0] opa_i = '0;
    logic [W-1:0] opb_i = '0;
    logic         cancel_i = 1'b0;
    logic         busy_o, done_o, div_zero_o;
    logic [W-1:0] hi_o, lo_o;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .opa_i(opa_i), .opb_i(opb_i), .cancel_i(cancel_i),
        .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o),
        .div_zero_o(div_zero_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int base);
        exp_t e;
        logic signed [63:0] sa, sbv;
        logic [63:0] p;
        sa    = {{32{a[31]}}, a};
        sbv   = {{32{b[31]}}, b};
        e.dz  = 1'b0;
        e.cyc = base + 2;
        e.hi  = '0;
        e.lo  = '0;
        case (op)
            2'b00: begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == '0) begin
                    e.hi = a; e.lo = '1; e.dz = 1'b1;
                end else if (op == 2'b10) begin
                    logic signed [63:0] sq, sr;
                    sq = sa / sbv; sr = sa % sbv;
                    e.hi = sr[31:0]; e.lo = sq[31:0]; e.cyc = base + DIV_LAT;
                end else begin
                    logic [63:0] uq, ur;
                    uq = {32'd0, a} / {32'd0, b}; ur = {32'd0, a} % {32'd0, b};
                    e.hi = ur[31:0]; e.lo = uq[31:0]; e.cyc = base + DIV_LAT;
                end
`else
                e.dz = 1'b1;
`endif
            end
        endcase
        return e;
    endfunction

    // Scoreboard: every done_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done_o) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done cyc=%0d hi=%h lo=%h", cyc, hi_o, lo_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checks++; if (hi_o !== e.hi) begin errors++; $display("FAIL sb_hi got=%h exp=%h", hi_o, e.hi); end
                checks++; if (lo_o !== e.lo) begin errors++; $display("FAIL sb_lo got=%h exp=%h", lo_o, e.lo); end
                checks++; if (div_zero_o !== e.dz) begin errors++; $display("FAIL sb_dz got=%b exp=%b", div_zero_o, e.dz); end
                checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL sb_latency got_cyc=%0d exp_cyc=%0d", cyc, e.cyc); end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        start_i = 1'b1; op_i = op; opa_i = a; opb_i = b;
        if (push) sb_q.push_back(model(op, a, b, cyc));
        @(negedge clk);
        start_i = 1'b0; op_i = 2'($urandom); opa_i = $urandom; opb_i = $urandom;
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 200 && (sb_q.size() != 0 || busy_o); i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0 || busy_o) begin
            errors++; $display("FAIL drain_timeout pending=%0d busy=%b", sb_q.size(), busy_o);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_quiet(input string name, input int n);
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done_o || busy_o) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL %s_quiet got=activity exp=none", name); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done_o); end
        checks++; if (hi_o !== '0) begin errors++; $display("FAIL rst_hi got=%h exp=0", hi_o); end
        checks++; if (lo_o !== '0) begin errors++; $display("FAIL rst_lo got=%h exp=0", lo_o); end
        checks++; if (div_zero_o !== 1'b0) begin errors++; $display("FAIL rst_dz got=%b exp=0", div_zero_o); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        issue(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1); wait_drain();
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_drain();
        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1); wait_drain();
        issue(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1); wait_drain();
        for (int i = 0; i < 6; i++) begin
            issue(2'($urandom_range(0, 1)), $urandom, $urandom, 1'b1);
            wait_drain();
        end
    endtask

    task automatic test_div();
        int nb = 0;
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
        for (int i = 0; i < 100 && busy_o; i++) begin nb++; @(negedge clk); end
        checks++; if (nb != DIV_LAT - 1) begin errors++; $display("FAIL div_busy_cycles got=%0d exp=%0d", nb, DIV_LAT - 1); end
        wait_drain();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_drain();
        issue(2'b11, 32'd100, 32'd0, 1'b1); wait_drain();
        checks++; if (div_zero_o !== 1'b1) begin errors++; $display("FAIL dz_hold got=%b exp=1", div_zero_o); end
        issue(2'b00, 32'd5, 32'd6, 1'b1);
        checks++; if (div_zero_o !== 1'b0) begin errors++; $display("FAIL dz_clear got=%b exp=0", div_zero_o); end
        wait_drain();
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] b;
            b = (i % 2 == 0) ? W'($urandom_range(1, 1000)) : $urandom;
            if (i == 3) b = -b;
            issue(2'($urandom_range(2, 3)), $urandom, b, 1'b1);
            wait_drain();
        end
    endtask

    task automatic test_cancel();
        logic [W-1:0] ph, pl;
        ph = hi_o; pl = lo_o;
        issue(2'b11, 32'd1000, 32'd7, 1'b0);
        repeat (CANCEL_AT - 1) @(negedge clk);
        cancel_i = 1'b1;
        @(negedge clk);
        cancel_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL cancel_busy got=%b exp=0", busy_o); end
        check_quiet("cancel", 40);
        checks++; if (hi_o !== ph) begin errors++; $display("FAIL cancel_hi got=%h exp=%h", hi_o, ph); end
        checks++; if (lo_o !== pl) begin errors++; $display("FAIL cancel_lo got=%h exp=%h", lo_o, pl); end
        // start together with cancel in IDLE must not be taken
        start_i = 1'b1; cancel_i = 1'b1; op_i = 2'b00;
        @(negedge clk);
        start_i = 1'b0; cancel_i = 1'b0;
        check_quiet("start_with_cancel", 4);
    endtask

    task automatic test_back_to_back();
        issue(2'b00, 32'hFFFF_FFF0, 32'd9, 1'b1);
        @(negedge clk);
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%b exp=1", done_o); end
        issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy_o); end
        wait_drain();
        // start held during MUL is ignored, and start+cancel in DONE goes idle
        issue(2'b01, 32'd77, 32'd3, 1'b1);
        start_i = 1'b1; op_i = 2'b00; opa_i = 32'd1; opb_i = 32'd1;
        @(negedge clk);
        start_i = 1'b1; cancel_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; cancel_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL done_cancel_busy got=%b exp=0", busy_o); end
        check_quiet("done_cancel", 4);
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL ignored_start_pending got=%0d exp=0", sb_q.size()); sb_q.delete(); end
    endtask

    task automatic test_reset_mid();
        issue(2'b11, 32'd1000, 32'd7, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy_o); end
        checks++; if (hi_o !== '0 || lo_o !== '0) begin errors++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", hi_o, lo_o); end
        checks++; if (div_zero_o !== 1'b0) begin errors++; $display("FAIL rstmid_dz got=%b exp=0", div_zero_o); end
        check_quiet("rstmid", 40);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_cancel();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, supported range 8..64.
REQ-002 Parameter CNT_W, default 6: iteration counter width, SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset (`RstEnable polarity).
REQ-005 Port start_i, input, 1: request a new operation.
REQ-006 Port op_i, input, 2: operation code: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-007 Port opa_i, input, WIDTH: multiplicand or dividend.
REQ-008 Port opb_i, input, WIDTH: multiplier or divisor.
REQ-009 Port cancel_i, input, 1: pipeline flush; aborts the operation in flight.
REQ-010 Port busy_o, output, 1: high while an operation is in flight (states MUL, DIV); drives the pipeline stall.
REQ-011 Port done_o, output, 1: one-cycle pulse when new results are valid.
REQ-012 Port hi_o, output, WIDTH: product high half, or remainder.
REQ-013 Port lo_o, output, WIDTH: product low half, or quotient.
REQ-014 Port div_zero_o, output, 1: set with done_o when the last division had opb_i == 0.

Function
REQ-015 FSM states SHALL be IDLE, MUL, DIV, DONE; done_o SHALL be high exactly in DONE.
REQ-016 start_i SHALL be accepted only in IDLE or DONE, and only when cancel_i is low; in MUL/DIV it SHALL be ignored.
REQ-017 On accept, opa_i, opb_i and op_i SHALL be captured into registers; later input changes SHALL have no effect.
REQ-018 MULT/MULTU: accepting edge -> MUL; the next edge SHALL write the full 2*WIDTH product and go to DONE; done_o latency 2 cycles after the accepting edge.
REQ-019 MULT SHALL treat operands as two's complement; MULTU as unsigned; {hi_o,lo_o} = full product with no truncation.
REQ-020 DIV/DIVU with opb != 0: restoring radix-2 divide, one quotient bit per cycle, exactly WIDTH cycles in DIV, then DONE; done_o latency WIDTH+1 cycles.
REQ-021 DIV SHALL divide magnitudes, then negate the quotient if the operand signs differ and give the remainder the sign of the dividend (truncate toward zero).
REQ-022 DIV with opa = most-negative and opb = -1 SHALL give lo_o = most-negative value and hi_o = 0, with no flag.
REQ-023 Divide by zero: DIV SHALL last 1 cycle, then DONE with lo_o = all-ones, hi_o = opa, div_zero_o = 1.
REQ-024 div_zero_o SHALL be cleared on every accepted start.
REQ-025 hi_o/lo_o SHALL change only on the edge entering DONE; they SHALL hold otherwise, including through cancel.
REQ-026 cancel_i high in MUL or DIV SHALL return to IDLE on the next edge, with no done_o pulse and results unchanged.
REQ-027 cancel_i high in DONE SHALL go to IDLE with no new accept.
REQ-028 Start accepted in DONE (back-to-back) SHALL go directly to MUL/DIV; done_o SHALL still pulse for the finishing op.
REQ-029 DONE with no new start SHALL return to IDLE next cycle.

Reset
REQ-030 rst high SHALL force IDLE and clear busy_o, done_o, hi_o, lo_o, div_zero_o and all internal registers on the next edge.
REQ-031 rst SHALL take priority over start_i and cancel_i, including mid-operation; no done_o pulse SHALL follow reset.

Configuration
REQ-032 Macro MULDIV_DIV_EN, when defined, SHALL compile in the divider datapath (REQ-020..023).
REQ-033 Without MULDIV_DIV_EN, DIV/DIVU SHALL be accepted and complete in 2 cycles with hi_o = lo_o = 0 and div_zero_o = 1; MULT behaviour SHALL be unchanged.

Verification
REQ-034 MULT, WIDTH=32, opa=0xFFFFFFFE (-2), opb=0x00000003 -> done_o 2 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 MULTU, opa=0xFFFFFFFF, opb=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 DIV, opa=-7 (0xFFFFFFF9), opb=2 -> done_o exactly 33 cycles after accept; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), busy_o high 32 cycles.
REQ-037 DIVU, opa=100, opb=0 -> done_o 2 cycles after accept; lo=0xFFFFFFFF, hi=100, div_zero_o=1; the next accepted MULT clears the flag.
REQ-038 DIVU 1000/7 with cancel_i pulsed at cycle 10 -> IDLE next cycle, no done_o, hi/lo keep previous values; rst pulsed mid-DIV -> all outputs 0.
REQ-039 Back-to-back: start MULT again in the DONE cycle of a MULT -> two done_o pulses 2 cycles apart, each carrying correct results.
